// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVERFLOW_EN to add a registered two's-complement overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carryout
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             c_next;

  // The single-bit full-adder cell fed by the operand LSBs and the running carry.
  assign s      = a_sr[0] ^ b_sr[0] ^ c;
  assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = s;
    end else begin : g_res_multi
      assign res_next = {s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c     <= carryin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c      <= c_next;
          res_sr <= res_next;
          cnt    <= cnt + CNT_ONE;
          // On the last bit, c is the carry into the MSB and c_next the carry out of it.
          if (cnt == LAST) begin
            sum      <= res_next;
            carryout <= c_next;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= c ^ c_next;
`endif
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, co1, sum1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       ov8, ov1;
  logic       prev_ov8, prev_ov1;
`endif

  logic [7:0] prev_sum8;
  logic       prev_co8;
  logic       prev_sum1, prev_co1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carryin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow(ov8),
`endif
    .carryout(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .carryin(cin1),
    .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow(ov1),
`endif
    .carryout(co1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 8-bit request from a non-edge time; returns #1 after the done edge.
  // glitch >= 0 pulses start (with a=FF) in that RUN cycle to show it is ignored.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic ci, input int glitch);
    logic [8:0] total;
    int n;
    total  = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
    a8     = av;
    b8     = bv;
    cin8   = ci;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    checkOutput("busy_accept", {63'b0, busy8}, 64'd1);
    checkOutput("done_accept", {63'b0, done8}, 64'd0);
    n = 0;
    while (n < 20) begin
      checkOutput("sum_hold", {56'b0, sum8}, {56'b0, prev_sum8});
      checkOutput("co_hold", {63'b0, co8}, {63'b0, prev_co8});
      checkOutput("busy_run", {63'b0, busy8}, 64'd1);
      if (n == glitch) begin
        start8 = 1'b1;
        a8     = 8'hFF;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      n++;
      if (done8) break;
    end
    checkOutput("done_seen", {63'b0, done8}, 64'd1);
    checkOutput("latency8", 64'(n), 64'd8);
    checkOutput("sum8", {56'b0, sum8}, {56'b0, total[7:0]});
    checkOutput("carryout8", {63'b0, co8}, {63'b0, total[8]});
    checkOutput("busy_done", {63'b0, busy8}, 64'd0);
    prev_sum8 = total[7:0];
    prev_co8  = total[8];
`ifdef SERIAL_ADDER_OVERFLOW_EN
    prev_ov8 = (av[7] == bv[7]) && (total[7] != av[7]);
    checkOutput("overflow8", {63'b0, ov8}, {63'b0, prev_ov8});
`endif
  endtask

  task automatic applyStimulusW1(input logic av, input logic bv, input logic ci);
    logic [1:0] total;
    int n;
    total  = {1'b0, av} + {1'b0, bv} + {1'b0, ci};
    a1     = av;
    b1     = bv;
    cin1   = ci;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checkOutput("w1_busy", {63'b0, busy1}, 64'd1);
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (done1) break;
    end
    checkOutput("w1_latency", 64'(n), 64'd1);
    checkOutput("w1_sum", {63'b0, sum1}, {63'b0, total[0]});
    checkOutput("w1_carryout", {63'b0, co1}, {63'b0, total[1]});
    prev_sum1 = total[0];
    prev_co1  = total[1];
`ifdef SERIAL_ADDER_OVERFLOW_EN
    prev_ov1 = (av == bv) && (total[0] != av);
    checkOutput("w1_overflow", {63'b0, ov1}, {63'b0, prev_ov1});
`endif
  endtask

  initial begin
    int done_count;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    prev_sum8 = '0; prev_co8 = 1'b0; prev_sum1 = 1'b0; prev_co1 = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    prev_ov8 = 1'b0; prev_ov1 = 1'b0;
`endif
    #12;
    checkOutput("rst_busy", {63'b0, busy8}, 64'd0);
    checkOutput("rst_done", {63'b0, done8}, 64'd0);
    checkOutput("rst_sum", {56'b0, sum8}, 64'd0);
    checkOutput("rst_co", {63'b0, co8}, 64'd0);
    checkOutput("rst_w1_sum", {62'b0, co1, sum1}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      applyStimulusW1(v[2], v[1], v[0]);
    end

    applyStimulus(8'hFF, 8'h01, 1'b0, -1);
    @(posedge clk); #1;
    checkOutput("done_pulse_width", {63'b0, done8}, 64'd0);
    applyStimulus(8'h5A, 8'hA5, 1'b1, -1);
    applyStimulus(8'h12, 8'h34, 1'b0, -1);
    applyStimulus(8'h0F, 8'h01, 1'b0, 2);
    applyStimulus(8'h7F, 8'h01, 1'b0, -1);
    applyStimulus(8'h80, 8'h80, 1'b0, -1);
    applyStimulus(8'h33, 8'h44, 1'b0, -1);

    // Abort a RUN in its fourth cycle.
    a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {63'b0, busy8}, 64'd0);
    checkOutput("abort_done", {63'b0, done8}, 64'd0);
    checkOutput("abort_sum", {56'b0, sum8}, 64'd0);
    checkOutput("abort_co", {63'b0, co8}, 64'd0);
    #1;
    rst_n = 1'b1;
    prev_sum8 = '0; prev_co8 = 1'b0; prev_sum1 = 1'b0; prev_co1 = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checkOutput("abort_ov", {63'b0, ov8}, 64'd0);
    prev_ov8 = 1'b0; prev_ov1 = 1'b0;
`endif
    done_count = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) done_count++;
    end
    checkOutput("abort_no_done", 64'(done_count), 64'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
